// File: rtl/jtcontra_pkg.sv
// Shared definitions for the Contra colour mixer: palette byte field positions
// and the transparency test applied to 007121 pixel indices.
package jtcontra_pkg;

  // Even byte {G[2:0],R[4:0]}, odd byte {x,B[4:0],G[4:3]}
  localparam int R_LSB    = 0;
  localparam int G_LO_LSB = 5;
  localparam int G_HI_LSB = 0;
  localparam int B_LSB    = 2;

  localparam logic [3:0] TRANSP_NIBBLE = 4'h0;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb_t;

  // A disabled layer looks exactly like a transparent pixel to the mixer
  function automatic logic is_transp(input logic [3:0] nib, input logic en);
    return ~en | (nib == TRANSP_NIBBLE);
  endfunction

  function automatic rgb_t unpack_colour(input logic [7:0] lo, input logic [7:0] hi);
    rgb_t c;
    c.r = lo[R_LSB +: 5];
    c.g = {hi[G_HI_LSB +: 2], lo[G_LO_LSB +: 3]};
    c.b = hi[B_LSB +: 5];
    return c;
  endfunction

endpackage

// File: rtl/jtcontra_colmix_pal.sv
// Palette storage: even/odd byte RAMs, CPU port with registered readback and a
// video port that fetches both bytes of one entry per strobe.
module jtcontra_colmix_pal #(
  parameter int PAL_AW = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_cen,
  input  logic              cpu_rnw,
  input  logic              pal_cs,
  input  logic [PAL_AW:0]   cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        pal_dout,
  input  logic              vid_rd,
  input  logic [PAL_AW-1:0] vid_idx,
  output logic [7:0]        vid_lo,
  output logic [7:0]        vid_hi
);
  import jtcontra_pkg::*;

  localparam int DEPTH = 1 << PAL_AW;

  logic [7:0]        ram_even [DEPTH];
  logic [7:0]        ram_odd  [DEPTH];
  logic              cpu_we;
  logic [PAL_AW-1:0] cpu_idx;

  assign cpu_we  = cpu_cen & pal_cs & ~cpu_rnw;
  assign cpu_idx = cpu_addr[PAL_AW:1];

  always_ff @(posedge clk) begin
    if (cpu_we && !cpu_addr[0]) ram_even[cpu_idx] <= cpu_dout;
    if (cpu_we &&  cpu_addr[0]) ram_odd[cpu_idx]  <= cpu_dout;
  end

  // Read-before-write: a video fetch colliding with a CPU write sees old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_dout <= 8'd0;
      vid_lo   <= 8'd0;
      vid_hi   <= 8'd0;
    end else begin
      pal_dout <= cpu_addr[0] ? ram_odd[cpu_idx] : ram_even[cpu_idx];
      if (vid_rd) begin
        vid_lo <= ram_even[vid_idx];
        vid_hi <= ram_odd[vid_idx];
      end
    end
  end

endmodule

// File: rtl/jtcontra_colmix.sv
// Colour mixer for two 007121 layers: priority/transparency selection, palette
// lookup and blanking delay aligned to the colour pipeline.
module jtcontra_colmix #(
  parameter int BLANK_DLY = 2,
  parameter int PAL_AW    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic              cpu_cen,
  input  logic              cpu_rnw,
  input  logic              pal_cs,
  input  logic [PAL_AW:0]   cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        pal_dout,
  input  logic [PAL_AW-1:0] gfx1_pxl,
  input  logic [PAL_AW-1:0] gfx2_pxl,
  input  logic              prio,
  input  logic [1:0]        gfx_en,
  output logic [4:0]        red,
  output logic [4:0]        green,
  output logic [4:0]        blue,
  output logic              LHBL_dly,
  output logic              LVBL_dly
);
  import jtcontra_pkg::*;

  logic [PAL_AW-1:0]    top_pxl;
  logic [PAL_AW-1:0]    bot_pxl;
  logic                 top_en;
  logic [PAL_AW-1:0]    pal_nxt;
  logic [PAL_AW-1:0]    pal_idx;
  logic                 rd_stb;
  logic [7:0]           vid_lo;
  logic [7:0]           vid_hi;
  logic [BLANK_DLY-1:0] hbl_sr;
  logic [BLANK_DLY-1:0] vbl_sr;
  rgb_t                 pal_col;

  // When the top layer is see-through the bottom index passes unchanged, so
  // a fully transparent pixel still shows the bottom bank's background colour.
  always_comb begin
    top_pxl = prio ? gfx2_pxl : gfx1_pxl;
    bot_pxl = prio ? gfx1_pxl : gfx2_pxl;
    top_en  = prio ? gfx_en[1] : gfx_en[0];
    pal_nxt = is_transp(top_pxl[3:0], top_en) ? bot_pxl : top_pxl;
  end

  assign pal_col = unpack_colour(vid_lo, vid_hi);

  jtcontra_colmix_pal #(.PAL_AW(PAL_AW)) u_pal (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_cen  (cpu_cen),
    .cpu_rnw  (cpu_rnw),
    .pal_cs   (pal_cs),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .vid_rd   (rd_stb),
    .vid_idx  (pal_idx),
    .vid_lo   (vid_lo),
    .vid_hi   (vid_hi)
  );

  // The palette is fetched once per pixel, on the clk following pxl_cen, so
  // pxl_cen must be at most every other clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_stb  <= 1'b0;
      pal_idx <= '0;
      hbl_sr  <= '0;
      vbl_sr  <= '0;
      red     <= 5'd0;
      green   <= 5'd0;
      blue    <= 5'd0;
    end else begin
      rd_stb <= pxl_cen;
      if (pxl_cen) begin
        pal_idx <= pal_nxt;
        hbl_sr  <= {hbl_sr[BLANK_DLY-2:0], LHBL};
        vbl_sr  <= {vbl_sr[BLANK_DLY-2:0], LVBL};
        if (hbl_sr[0] && vbl_sr[0]) begin
          red   <= pal_col.r;
          green <= pal_col.g;
          blue  <= pal_col.b;
        end else begin
          red   <= 5'd0;
          green <= 5'd0;
          blue  <= 5'd0;
        end
      end
    end
  end

  assign LHBL_dly = hbl_sr[BLANK_DLY-1];
  assign LVBL_dly = vbl_sr[BLANK_DLY-1];

endmodule

// File: tb/tb_jtcontra_colmix.sv
// Bench for jtcontra_colmix: directed and random pixels against a palette
// model and an expected-output queue, plus CPU readback and reset checks.
module tb_jtcontra_colmix;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic       LVBL = 1'b1;
  logic       cpu_cen = 1'b0;
  logic       cpu_rnw = 1'b1;
  logic       pal_cs = 1'b0;
  logic [7:0] cpu_addr = 8'd0;
  logic [7:0] cpu_dout = 8'd0;
  logic [7:0] pal_dout;
  logic [6:0] gfx1_pxl = 7'd0;
  logic [6:0] gfx2_pxl = 7'd0;
  logic       prio = 1'b0;
  logic [1:0] gfx_en = 2'b11;
  logic [4:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  pal_m [256];
  logic [16:0] exp_q [$];   // {r, g, b, LHBL_dly, LVBL_dly}

  jtcontra_colmix dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .cpu_cen  (cpu_cen),
    .cpu_rnw  (cpu_rnw),
    .pal_cs   (pal_cs),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .gfx1_pxl (gfx1_pxl),
    .gfx2_pxl (gfx2_pxl),
    .prio     (prio),
    .gfx_en   (gfx_en),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: choose the index from the layer rules, then decode palette bytes
  function automatic logic [16:0] model(input logic [6:0] g1, input logic [6:0] g2,
                                        input logic pr, input logic [1:0] en,
                                        input logic hb, input logic vb);
    int top, bot, idx, lo, hi, r, g, b;
    bit top_vis;
    top     = pr ? int'(g2) : int'(g1);
    bot     = pr ? int'(g1) : int'(g2);
    top_vis = (pr ? en[1] : en[0]) && (top % 16 != 0);
    idx     = top_vis ? top : bot;
    if (!(hb && vb)) return {15'd0, hb, vb};
    lo = int'(pal_m[2 * idx]);
    hi = int'(pal_m[2 * idx + 1]);
    r  = lo % 32;
    g  = lo / 32 + (hi % 4) * 8;
    b  = (hi / 4) % 32;
    return {5'(r), 5'(g), 5'(b), hb, vb};
  endfunction

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    cpu_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
    @(posedge clk); #1;
    cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
    pal_m[a] = d;
  endtask

  task automatic cpu_rd(input logic [7:0] a);
    cpu_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
    @(posedge clk); #1;
    cpu_cen = 1'b0; pal_cs = 1'b0;
    check("pal_readback", 32'(pal_dout), 32'(pal_m[a]));
  endtask

  // One pixel of 4 clks; optional CPU write lands on the video fetch clk.
  // Outputs after the pixel reflect the previous pixel's inputs.
  task automatic px(input logic [6:0] g1, input logic [6:0] g2, input logic pr,
                    input logic [1:0] en, input logic hb, input logic vb,
                    input bit wr = 1'b0, input logic [7:0] wa = 8'd0,
                    input logic [7:0] wd = 8'd0);
    logic [16:0] e;
    gfx1_pxl = g1; gfx2_pxl = g2; prio = pr; gfx_en = en; LHBL = hb; LVBL = vb;
    exp_q.push_back(model(g1, g2, pr, en, hb, vb));
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    if (wr) begin
      cpu_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = wa; cpu_dout = wd;
    end
    @(posedge clk); #1;
    cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
    if (wr) pal_m[wa] = wd;
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pixel_rgb", 32'({red, green, blue}), 32'(e[16:2]));
    check("pixel_blank", 32'({LHBL_dly, LVBL_dly}), 32'(e[1:0]));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", 32'({red, green, blue}), 32'd0);
    check("reset_dly", 32'({LHBL_dly, LVBL_dly}), 32'd0);
    check("reset_pal_dout", 32'(pal_dout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) cpu_wr(8'(i), 8'($urandom_range(0, 255)));
    cpu_wr(8'h10, 8'h1F);
    cpu_wr(8'h11, 8'h00);
    cpu_rd(8'h10);
    check("readback_0x10", 32'(pal_dout), 32'h1F);
    cpu_wr(8'h82, 8'h00);
    cpu_wr(8'h83, 8'h7C);
    for (int i = 0; i < 8; i++) cpu_rd(8'($urandom_range(0, 255)));

    exp_q.delete();
    exp_q.push_back(17'd0);

    // Basic colour
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    check("first_red", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd0}));

    // Priority
    px(7'h08, 7'h41, 1'b0, 2'b11, 1'b1, 1'b1);
    px(7'h08, 7'h41, 1'b1, 2'b11, 1'b1, 1'b1);
    check("prio0_red", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd0}));
    px(7'h08, 7'h41, 1'b1, 2'b11, 1'b1, 1'b1);
    check("prio1_blue", 32'({red, green, blue}), 32'({5'd0, 5'd0, 5'd31}));

    // Transparency, layer gating and the both-transparent background case
    px(7'h10, 7'h41, 1'b0, 2'b11, 1'b1, 1'b1);
    px(7'h08, 7'h41, 1'b0, 2'b10, 1'b1, 1'b1);
    check("transp_gfx2", 32'({red, green, blue}), 32'({5'd0, 5'd0, 5'd31}));
    px(7'h10, 7'h20, 1'b0, 2'b11, 1'b1, 1'b1);
    check("gated_gfx2", 32'({red, green, blue}), 32'({5'd0, 5'd0, 5'd31}));
    px(7'h10, 7'h20, 1'b1, 2'b11, 1'b1, 1'b1);
    px(7'h08, 7'h41, 1'b0, 2'b00, 1'b1, 1'b1);

    // Blanking: three pixels of LHBL low, then one of LVBL low
    for (int i = 0; i < 9; i++)
      px(7'h08, 7'h41, 1'b0, 2'b11, !(i >= 2 && i < 5), (i != 7));

    // Random mix
    for (int i = 0; i < 60; i++) begin
      logic [6:0] g1, g2;
      g1 = 7'($urandom_range(0, 127));
      g2 = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) g1[3:0] = 4'h0;
      if ($urandom_range(0, 3) == 0) g2[3:0] = 4'h0;
      px(g1, g2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0));
    end

    // Collision: restore entry 0x08 to pure red, then write its blue byte
    // on the same clk the video fetches it
    cpu_wr(8'h10, 8'h1F);
    cpu_wr(8'h11, 8'h00);
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 8'h11, 8'h7C);
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    check("collision_old", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd0}));
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    check("collision_new", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd31}));

    // Asynchronous reset between clk edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 32'({red, green, blue}), 32'd0);
    check("async_rst_dly", 32'({LHBL_dly, LVBL_dly}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(17'd0);
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    px(7'h08, 7'h00, 1'b0, 2'b11, 1'b1, 1'b1);
    check("post_rst_colour", 32'({red, green, blue}), 32'({5'd31, 5'd0, 5'd31}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
